// File: rtl/id_operand_issue_if.sv
// Bundle of decode-side, forwarding and EX-side signals for the operand
// resolve / issue stage. The stage itself uses the slave view; the
// surrounding pipeline (or a bench) drives through the master view.
interface id_operand_issue_if #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5,
  parameter int FWD_CH = 3,
  parameter int SB_W   = 16,
  parameter int CNT_W  = 16
) ();
  // decode side
  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_W-1:0]        in_pc;
  logic                     in_re1;
  logic                     in_re2;
  logic [RA_W-1:0]          in_ra1;
  logic [RA_W-1:0]          in_ra2;
  logic [DATA_W-1:0]        in_imm;
  logic [RA_W-1:0]          in_wd;
  logic                     in_wreg;
  logic [SB_W-1:0]          in_sb;
  // register file read data
  logic [DATA_W-1:0]        rf_rd1;
  logic [DATA_W-1:0]        rf_rd2;
  // forwarding channels, index 0 is the youngest
  logic [FWD_CH-1:0]        fwd_wreg;
  logic [FWD_CH-1:0]        fwd_rdy;
  logic [FWD_CH*RA_W-1:0]   fwd_addr;
  logic [FWD_CH*DATA_W-1:0] fwd_data;
  // EX side
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_pc;
  logic [DATA_W-1:0]        out_op1;
  logic [DATA_W-1:0]        out_op2;
  logic [RA_W-1:0]          out_wd;
  logic                     out_wreg;
  logic [SB_W-1:0]          out_sb;
  // status
  logic                     hazard;
  logic [CNT_W-1:0]         stall_cnt;

  modport slave (
    input  flush, in_valid, in_pc, in_re1, in_re2, in_ra1, in_ra2, in_imm,
           in_wd, in_wreg, in_sb, rf_rd1, rf_rd2,
           fwd_wreg, fwd_rdy, fwd_addr, fwd_data, out_ready,
    output in_ready, out_valid, out_pc, out_op1, out_op2, out_wd, out_wreg,
           out_sb, hazard, stall_cnt
  );

  modport master (
    output flush, in_valid, in_pc, in_re1, in_re2, in_ra1, in_ra2, in_imm,
           in_wd, in_wreg, in_sb, rf_rd1, rf_rd2,
           fwd_wreg, fwd_rdy, fwd_addr, fwd_data, out_ready,
    input  in_ready, out_valid, out_pc, out_op1, out_op2, out_wd, out_wreg,
           out_sb, hazard, stall_cnt
  );
endinterface

// File: rtl/id_operand_issue.sv
// Operand resolve and issue stage between decode and EX. Each source operand
// comes from the immediate, r0 (zero), the youngest matching forwarding
// channel, or the register file. A matching channel whose data is not yet
// available (pending load) blocks issue and a bubble is sent instead.
module id_operand_issue #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5,
  parameter int FWD_CH = 3,
  parameter int SB_W   = 16,
  parameter int CNT_W  = 16
) (
  input logic               clk,
  input logic               rst,
  id_operand_issue_if.slave bus
);

  // Returns {blocked, value} for one source operand. The loop walks from the
  // oldest channel to the youngest so the youngest match overwrites the rest;
  // a younger match that is not ready therefore blocks even when an older
  // channel holds ready data for the same register.
  function automatic logic [DATA_W:0] resolve(
    input logic                     re,
    input logic [RA_W-1:0]          ra,
    input logic [DATA_W-1:0]        rf,
    input logic [DATA_W-1:0]        imm,
    input logic [FWD_CH-1:0]        fw,
    input logic [FWD_CH-1:0]        fr,
    input logic [FWD_CH*RA_W-1:0]   fa,
    input logic [FWD_CH*DATA_W-1:0] fd
  );
    logic [DATA_W-1:0] val;
    logic              blk;
    val = rf;
    blk = 1'b0;
    for (int k = FWD_CH - 1; k >= 0; k--) begin
      if (fw[k] && (fa[k*RA_W +: RA_W] == ra)) begin
        val = fd[k*DATA_W +: DATA_W];
        blk = !fr[k];
      end
    end
    if (ra == '0) begin
      val = '0;
      blk = 1'b0;
    end
    if (!re) begin
      val = imm;
      blk = 1'b0;
    end
    return {blk, val};
  endfunction

  logic [DATA_W:0]   res1;
  logic [DATA_W:0]   res2;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic              blocked1;
  logic              blocked2;
  logic              hazard;
  logic              free;
  logic              in_ready;
  logic              accept;

  logic              out_valid_q;
  logic [DATA_W-1:0] out_pc_q;
  logic [DATA_W-1:0] out_op1_q;
  logic [DATA_W-1:0] out_op2_q;
  logic [RA_W-1:0]   out_wd_q;
  logic              out_wreg_q;
  logic [SB_W-1:0]   out_sb_q;
  logic [CNT_W-1:0]  stall_cnt_q;

  // Resolve both source operands and flag a load-use block on either one.
  always_comb begin
    res1 = resolve(bus.in_re1, bus.in_ra1, bus.rf_rd1, bus.in_imm,
                   bus.fwd_wreg, bus.fwd_rdy, bus.fwd_addr, bus.fwd_data);
    res2 = resolve(bus.in_re2, bus.in_ra2, bus.rf_rd2, bus.in_imm,
                   bus.fwd_wreg, bus.fwd_rdy, bus.fwd_addr, bus.fwd_data);
    op1      = res1[DATA_W-1:0];
    blocked1 = res1[DATA_W];
    op2      = res2[DATA_W-1:0];
    blocked2 = res2[DATA_W];
  end

  // The slot can take a new instruction when empty or being drained this cycle.
  always_comb begin
    hazard   = bus.in_valid & (blocked1 | blocked2);
    free     = !out_valid_q | bus.out_ready;
    in_ready = free & !hazard & !bus.flush & !rst;
    accept   = bus.in_valid & in_ready;
  end

  // ID/EX slot: flush squashes, accept captures, a free slot without capture
  // becomes a bubble, otherwise the held instruction stays put for EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_op1_q   <= '0;
      out_op2_q   <= '0;
      out_wd_q    <= '0;
      out_wreg_q  <= 1'b0;
      out_sb_q    <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_pc_q    <= bus.in_pc;
      out_op1_q   <= op1;
      out_op2_q   <= op2;
      out_wd_q    <= bus.in_wd;
      out_wreg_q  <= bus.in_wreg;
      out_sb_q    <= bus.in_sb;
    end else if (free) begin
      out_valid_q <= 1'b0;
    end
  end

  // Count cycles lost to load-use hazards, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (hazard && free && !bus.flush && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.hazard    = hazard;
  assign bus.out_valid = out_valid_q;
  assign bus.out_pc    = out_pc_q;
  assign bus.out_op1   = out_op1_q;
  assign bus.out_op2   = out_op2_q;
  assign bus.out_wd    = out_wd_q;
  assign bus.out_wreg  = out_wreg_q;
  assign bus.out_sb    = out_sb_q;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_operand_issue.sv
// Scoreboard bench for id_operand_issue: directed vectors push their
// hand-computed issue results into a queue, and a monitor pops and compares
// every instruction EX consumes.
module tb_id_operand_issue;
  localparam int DATA_W = 32;
  localparam int RA_W   = 5;
  localparam int FWD_CH = 3;
  localparam int SB_W   = 16;
  localparam int CNT_W  = 4;

  typedef struct {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [RA_W-1:0]   wd;
    logic              wreg;
    logic [SB_W-1:0]   sb;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  id_operand_issue_if #(.DATA_W(DATA_W), .RA_W(RA_W), .FWD_CH(FWD_CH),
                        .SB_W(SB_W), .CNT_W(CNT_W)) bus ();

  id_operand_issue #(.DATA_W(DATA_W), .RA_W(RA_W), .FWD_CH(FWD_CH),
                     .SB_W(SB_W), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // free-running clock
  always #5 clk = ~clk;

  // one comparison with a failure report
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // consume side: every instruction EX takes must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_issue: got pc 0x%0h, expected nothing",
                 bus.out_pc);
      end else begin
        e = exp_q.pop_front();
        checkOutput("issue_pc",   bus.out_pc,  e.pc);
        checkOutput("issue_op1",  bus.out_op1, e.op1);
        checkOutput("issue_op2",  bus.out_op2, e.op2);
        checkOutput("issue_wd",   32'(bus.out_wd),   32'(e.wd));
        checkOutput("issue_wreg", 32'(bus.out_wreg), 32'(e.wreg));
        checkOutput("issue_sb",   32'(bus.out_sb),   32'(e.sb));
      end
    end
  end

  // present the current inputs for one cycle, check the handshake and
  // record the expected issue if the vector should be accepted
  task automatic applyStimulus(input string name, input bit exp_hazard,
                               input bit exp_accept,
                               input logic [DATA_W-1:0] e1,
                               input logic [DATA_W-1:0] e2);
    exp_t e;
    bus.in_valid = 1'b1;
    @(negedge clk);
    checkOutput({name, "_hazard"},   32'(bus.hazard),   32'(exp_hazard));
    checkOutput({name, "_in_ready"}, 32'(bus.in_ready), 32'(exp_accept));
    if (exp_accept) begin
      e.pc   = bus.in_pc;
      e.op1  = e1;
      e.op2  = e2;
      e.wd   = bus.in_wd;
      e.wreg = bus.in_wreg;
      e.sb   = bus.in_sb;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic clearInputs();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_pc    = '0;
    bus.in_re1   = 1'b1;
    bus.in_re2   = 1'b1;
    bus.in_ra1   = '0;
    bus.in_ra2   = '0;
    bus.in_imm   = '0;
    bus.in_wd    = '0;
    bus.in_wreg  = 1'b0;
    bus.in_sb    = '0;
    bus.rf_rd1   = '0;
    bus.rf_rd2   = '0;
    bus.fwd_wreg = '0;
    bus.fwd_rdy  = '1;
    bus.fwd_addr = '0;
    bus.fwd_data = '0;
  endtask

  task automatic setChannel(input int k, input logic [RA_W-1:0] a,
                            input logic [DATA_W-1:0] d);
    bus.fwd_addr[k*RA_W +: RA_W]     = a;
    bus.fwd_data[k*DATA_W +: DATA_W] = d;
  endtask

  // overall time bound
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.out_ready = 1'b1;
    clearInputs();
    doReset();

    // plain issue from the register file
    bus.in_pc = 32'h100; bus.in_ra1 = 5'd3; bus.in_ra2 = 5'd4;
    bus.rf_rd1 = 32'h11; bus.rf_rd2 = 32'h22;
    bus.in_wd = 5'd9; bus.in_wreg = 1'b1; bus.in_sb = 16'h5a5a;
    applyStimulus("plain", 1'b0, 1'b1, 32'h11, 32'h22);
    checkOutput("plain_latency", 32'(bus.out_valid), 32'd1);
    idle(1);

    // reset while an instruction is held must discard it
    bus.in_pc = 32'h104; bus.rf_rd1 = 32'h77;
    applyStimulus("victim", 1'b0, 1'b1, 32'h77, 32'h22);
    bus.out_ready = 1'b0;
    idle(1);
    checkOutput("victim_held", 32'(bus.out_valid), 32'd1);
    doReset();
    bus.out_ready = 1'b1;
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_pc",    bus.out_pc,  32'd0);
    checkOutput("rst_out_op1",   bus.out_op1, 32'd0);
    checkOutput("rst_out_sb",    32'(bus.out_sb),   32'd0);
    checkOutput("rst_out_wreg",  32'(bus.out_wreg), 32'd0);
    checkOutput("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);

    // forwarding priority, issued back to back
    clearInputs();
    bus.in_pc = 32'h200; bus.in_ra1 = 5'd5; bus.in_ra2 = 5'd6;
    bus.rf_rd1 = 32'h55; bus.rf_rd2 = 32'h66;
    setChannel(0, 5'd5, 32'hAAAA); setChannel(1, 5'd5, 32'hBBBB);
    bus.fwd_wreg = 3'b011;
    applyStimulus("prio_ch0", 1'b0, 1'b1, 32'hAAAA, 32'h66);
    bus.in_pc = 32'h204; setChannel(0, 5'd8, 32'hAAAA);
    applyStimulus("prio_ch1", 1'b0, 1'b1, 32'hBBBB, 32'h66);
    checkOutput("b2b_valid", 32'(bus.out_valid), 32'd1);
    bus.in_pc = 32'h208; setChannel(2, 5'd5, 32'hCCCC); bus.fwd_wreg = 3'b100;
    applyStimulus("prio_ch2", 1'b0, 1'b1, 32'hCCCC, 32'h66);
    idle(2);

    // load-use stall then release
    doReset();
    clearInputs();
    bus.in_pc = 32'h300; bus.in_ra1 = 5'd1; bus.in_ra2 = 5'd2;
    bus.rf_rd1 = 32'h1; bus.rf_rd2 = 32'h2;
    applyStimulus("lu_prev", 1'b0, 1'b1, 32'h1, 32'h2);
    bus.in_pc = 32'h304; bus.in_ra2 = 5'd7;
    setChannel(0, 5'd7, 32'hDEAD); bus.fwd_wreg = 3'b001; bus.fwd_rdy = 3'b000;
    for (int i = 0; i < 3; i++) begin
      applyStimulus("lu_stall", 1'b1, 1'b0, 32'h0, 32'h0);
      checkOutput("lu_bubble", 32'(bus.out_valid), 32'd0);
    end
    checkOutput("lu_stall_cnt", 32'(bus.stall_cnt), 32'd3);
    bus.in_valid = 1'b0;
    #1;
    checkOutput("lu_no_valid_hazard", 32'(bus.hazard), 32'd0);
    bus.fwd_rdy = 3'b001; setChannel(0, 5'd7, 32'h1234);
    applyStimulus("lu_release", 1'b0, 1'b1, 32'h1, 32'h1234);
    checkOutput("lu_cnt_after", 32'(bus.stall_cnt), 32'd3);
    // younger channel pending blocks even though an older one is ready
    bus.in_pc = 32'h308; setChannel(1, 5'd7, 32'h9999);
    bus.fwd_wreg = 3'b011; bus.fwd_rdy = 3'b010;
    applyStimulus("young_block", 1'b1, 1'b0, 32'h0, 32'h0);
    idle(2);

    // r0 is never forwarded, immediate overrides any match
    clearInputs();
    bus.in_pc = 32'h400; bus.in_ra1 = 5'd0; bus.in_ra2 = 5'd3;
    bus.rf_rd1 = 32'h99; bus.rf_rd2 = 32'h33;
    setChannel(0, 5'd0, 32'hFFFF); bus.fwd_wreg = 3'b001; bus.fwd_rdy = 3'b000;
    applyStimulus("r0", 1'b0, 1'b1, 32'h0, 32'h33);
    bus.in_pc = 32'h404; bus.in_ra1 = 5'd2; bus.rf_rd1 = 32'h22;
    bus.in_re2 = 1'b0; bus.in_ra2 = 5'd5; bus.in_imm = 32'h0000_8000;
    setChannel(0, 5'd5, 32'hFFFF);
    applyStimulus("imm", 1'b0, 1'b1, 32'h22, 32'h8000);
    idle(2);

    // backpressure holds the slot, then flush squashes it
    clearInputs();
    bus.in_pc = 32'h500; bus.in_ra1 = 5'd3; bus.in_ra2 = 5'd4;
    bus.rf_rd1 = 32'h31; bus.rf_rd2 = 32'h41;
    bus.in_wd = 5'd12; bus.in_wreg = 1'b1; bus.in_sb = 16'hBEEF;
    applyStimulus("bp_a", 1'b0, 1'b1, 32'h31, 32'h41);
    bus.out_ready = 1'b0;
    bus.in_pc = 32'h600; bus.rf_rd1 = 32'h61;
    for (int i = 0; i < 4; i++) begin
      applyStimulus("bp_hold", 1'b0, 1'b0, 32'h0, 32'h0);
      checkOutput("bp_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("bp_pc",    bus.out_pc,  32'h500);
      checkOutput("bp_op1",   bus.out_op1, 32'h31);
      checkOutput("bp_sb",    32'(bus.out_sb), 32'hBEEF);
    end
    bus.flush = 1'b1;
    applyStimulus("flush", 1'b0, 1'b0, 32'h0, 32'h0);
    bus.flush = 1'b0;
    checkOutput("flush_valid", 32'(bus.out_valid), 32'd0);
    exp_q.delete();
    bus.out_ready = 1'b1;
    idle(2);
    checkOutput("flush_no_capture", 32'(bus.out_valid), 32'd0);

    // stall counter saturation
    doReset();
    clearInputs();
    bus.in_pc = 32'h700; bus.in_ra1 = 5'd9;
    setChannel(0, 5'd9, 32'h0); bus.fwd_wreg = 3'b001; bus.fwd_rdy = 3'b000;
    for (int i = 0; i < 20; i++) begin
      applyStimulus("sat", 1'b1, 1'b0, 32'h0, 32'h0);
      if (i == 9)  checkOutput("sat_cnt10", 32'(bus.stall_cnt), 32'd10);
      if (i == 14) checkOutput("sat_cnt15", 32'(bus.stall_cnt), 32'd15);
    end
    checkOutput("sat_hold", 32'(bus.stall_cnt), 32'd15);
    idle(2);

    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_operand_issue.md
Name: id_operand_issue

Overview:
- Parametrised operand-resolve and issue stage between decode and EX.
- Takes one decoded instruction per handshake and resolves both source operands from: the register file, N forwarding channels ordered youngest first, or the immediate.
- Detects load-use hazards and inserts bubbles.
- Holds the result in a registered ID/EX slot with valid/ready flow control, flush, and a stall performance counter.

Parameters:
- DATA_W, 32, operand/data width
- RA_W, 5, register address width
- FWD_CH, 3, number of forwarding channels; index 0 = youngest (EX), then MEM, WB
- SB_W, 16, opaque sideband width (aluop/alusel), passed through unchanged
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  squash held and incoming instruction
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts this cycle
- in_pc  in  DATA_W  instruction PC
- in_re1, in_re2  in  1 each  operand 1/2 read register (else use in_imm)
- in_ra1, in_ra2  in  RA_W each  source register addresses
- in_imm  in  DATA_W  extended immediate
- in_wd  in  RA_W  destination register
- in_wreg  in  1  destination write enable
- in_sb  in  SB_W  sideband
- rf_rd1, rf_rd2  in  DATA_W each  register-file read data for in_ra1/in_ra2, combinational
- fwd_wreg  in  FWD_CH  channel k writes a register
- fwd_rdy  in  FWD_CH  channel k data is available (0 = load still pending)
- fwd_addr  in  FWD_CH*RA_W  channel k dest, slice [k*RA_W +: RA_W]
- fwd_data  in  FWD_CH*DATA_W  channel k data
- out_valid  out  1  issue slot valid
- out_ready  in  1  EX accepts
- out_pc, out_op1, out_op2  out  DATA_W each  registered PC/operands
- out_wd  out  RA_W  registered destination
- out_wreg  out  1  registered write enable
- out_sb  out  SB_W  registered sideband
- hazard  out  1  combinational: load-use hazard on the current input
- stall_cnt  out  CNT_W  saturating count of hazard-stalled cycles

Behaviour:
- Reset: all out_* = 0, out_valid = 0, stall_cnt = 0. Reset mid-transfer discards the held instruction. in_ready = 0 while rst = 1.
- Operand resolve (combinational, per operand j):
  - in_rej = 0: opj = in_imm.
  - in_rej = 1 and in_raj == 0: opj = 0. Never forwarded, even if a channel targets r0.
  - Otherwise match = lowest k with fwd_wreg[k] = 1 and fwd_addr[k] == in_raj.
  - If a match exists: opj = fwd_data[k], and the operand is blocked if fwd_rdy[k] = 0. Older channels are never consulted when a younger one matches, even if the younger is not ready.
  - No match: opj = rf_rdj.
- hazard = in_valid & (blocked1 | blocked2).
- Issue slot: free = !out_valid | out_ready. in_ready = free & !hazard & !flush.
- Each clock edge, priority order:
  1. rst.
  2. flush: out_valid <= 0; nothing captured.
  3. in_valid & in_ready: capture resolved operands and all in_* fields; out_valid <= 1.
  4. free (no capture): out_valid <= 0, i.e. a bubble on hazard or no input.
  5. Otherwise hold all out_* stable. Required: no change while out_valid & !out_ready.
- Simultaneous consume and capture in the same cycle: back-to-back, full throughput, no bubble.
- stall_cnt: increments when hazard & free & !flush. Saturates at all-ones; no wrap. Cleared only by rst.
- Latency: 1 cycle from accepted input to out_valid.
- Combinational paths: no combinational path from out_ready to any out_*. in_ready depends combinationally on out_ready.

Test Plan:
- Plain issue: rf_rd1=0x11, rf_rd2=0x22, no channel match, re1=re2=1 -> next cycle out_valid=1, op1=0x11, op2=0x22.
- Priority: ch0 and ch1 both target r5 with data 0xAAAA/0xBBBB, all ready, ra1=5 -> op1=0xAAAA. Drop ch0 match -> op1=0xBBBB.
- Load-use: ch0 wreg=1, addr=7, rdy=0, ra2=7 for 3 cycles, then rdy=1 with data 0x1234:
  - during the stall: hazard=1, in_ready=0, out_valid=0 bubbles, stall_cnt=3;
  - on release: op2=0x1234.
- r0 and immediate:
  - ra1=0, ch0 targets r0 with 0xFFFF -> op1=0.
  - re2=0, imm=0x0000_8000 -> op2=0x8000, even with ch0 matching ra2.
- Backpressure/flush: out_ready=0 for 4 cycles -> out_* stable, in_ready=0. Then assert flush with in_valid=1 -> out_valid=0 next cycle, input not captured.
- Saturation: CNT_W=4, hold a hazard 20 cycles -> stall_cnt=15, stays 15.
